// File: rtl/adc_trig_fifo_writer.sv
// Trigger-driven ADC capture engine feeding a 32-bit FIFO sink port.
// An accepted trigger produces one header, NSAMPLES/2 packed data words
// and a trailer. A small word buffer sits between capture and the sink
// so that sink back-pressure does not stall capture.
module adc_trig_fifo_writer #(
  parameter int unsigned NSAMPLES  = 64,
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] adc_data,
  input  logic        write_en,
  input  logic        exttrg,
  output logic [31:0] fifo_writedata,
  output logic        fifo_write,
  input  logic        fifo_waitrequest,
  output logic        busy,
  output logic        ovf,
  output logic [23:0] event_count,
  output logic [15:0] trg_missed
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_TRL  = 2'd3;

  localparam logic [15:0] NS16   = 16'(NSAMPLES);
  localparam logic [15:0] LAST   = 16'(NSAMPLES - 1);
  localparam logic [AW:0] FULL_N = (AW + 1)'(BUF_DEPTH);

  // Capture FSM state
  logic [1:0]  state_q, state_d;
  logic        trg_prev_q;
  logic [15:0] smp_q, smp_d;
  logic [13:0] held_q, held_d;
  logic        ovf_q, ovf_d;
  logic        ovf_evt_q, ovf_evt_d;
  logic [23:0] event_count_q, event_count_d;
  logic [15:0] missed_q, missed_d;

  // Word buffer
  logic [31:0] mem_q [BUF_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;

  // Sink-side output registers
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        trg_edge;
  logic        buf_full, buf_empty;
  logic        pop, space;
  logic        push;
  logic [31:0] push_data;

  assign trg_edge  = exttrg & ~trg_prev_q;
  assign buf_full  = (count_q == FULL_N);
  assign buf_empty = (count_q == '0);
  // A word leaves the buffer whenever the output register is free or
  // being accepted this cycle; a same-cycle pop frees a slot for a push.
  assign pop       = ~buf_empty & (~wr_q | ~fifo_waitrequest);
  assign space     = ~buf_full | pop;

  // Capture FSM: framing, packing, drop accounting and counters
  always_comb begin
    state_d       = state_q;
    smp_d         = smp_q;
    held_d        = held_q;
    ovf_d         = ovf_q;
    ovf_evt_d     = ovf_evt_q;
    event_count_d = event_count_q;
    missed_d      = missed_q;
    push          = 1'b0;
    push_data     = '0;
    case (state_q)
      S_IDLE: begin
        if (trg_edge & write_en) begin
          if (!buf_full) begin
            state_d   = S_HDR;
            ovf_evt_d = 1'b0;
          end else if (missed_q != '1) begin
            missed_d = missed_q + 16'd1;
          end
        end
      end
      // Header always fits: nothing pushes between acceptance and here.
      S_HDR: begin
        push      = 1'b1;
        push_data = {8'hA5, event_count_q};
        smp_d     = '0;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        if (!smp_q[0]) begin
          held_d = adc_data;
        end else begin
          push_data = {2'b10, held_q, 2'b00, adc_data};
          if (space) begin
            push = 1'b1;
          end else begin
            ovf_d     = 1'b1;
            ovf_evt_d = 1'b1;
          end
        end
        if (smp_q == LAST) begin
          smp_d   = '0;
          state_d = S_TRL;
        end else begin
          smp_d = smp_q + 16'd1;
        end
      end
      default: begin
        if (space) begin
          push          = 1'b1;
          push_data     = {8'h5A, 7'b0, ovf_evt_q, NS16};
          event_count_d = event_count_q + 24'd1;
          state_d       = S_IDLE;
        end
      end
    endcase
  end

  // Buffer occupancy and sink-side load/hold/release
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (pop) begin
      wr_d    = 1'b1;
      wdata_d = mem_q[rptr_q];
    end else if (wr_q & ~fifo_waitrequest) begin
      wr_d = 1'b0;
    end
  end

  // Control registers; reset aborts any event and flushes the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      trg_prev_q    <= 1'b0;
      smp_q         <= '0;
      held_q        <= '0;
      ovf_q         <= 1'b0;
      ovf_evt_q     <= 1'b0;
      event_count_q <= '0;
      missed_q      <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      trg_prev_q    <= exttrg;
      smp_q         <= smp_d;
      held_q        <= held_d;
      ovf_q         <= ovf_d;
      ovf_evt_q     <= ovf_evt_d;
      event_count_q <= event_count_d;
      missed_q      <= missed_d;
      count_q       <= count_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // Buffer storage; contents are don't-care once pointers are reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign fifo_writedata = wdata_q;
  assign fifo_write     = wr_q;
  assign busy           = (state_q != S_IDLE);
  assign ovf            = ovf_q;
  assign event_count    = event_count_q;
  assign trg_missed     = missed_q;

endmodule

// File: doc/adc_trig_fifo_writer.md
Name: adc_trig_fifo_writer

Overview:
- Trigger-driven ADC capture engine and the writing end of the 32-bit FIFO sink port (writedata/write/waitrequest) on the readout system.
- On an exttrg rising edge, while write_en is high, it captures NSAMPLES consecutive 14-bit ADC samples and packs them two per word.
- Each event is framed as header, data words, trailer; an internal word buffer absorbs FIFO back-pressure.
- One instance per ADC channel (bs1 → fifo_0, bs2 → fifo_1).

Parameters:
- NSAMPLES, 64, samples per event; even, range 2..65534.
- BUF_DEPTH, 16, internal word buffer depth; power of two, at least 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- adc_data  in  14  ADC sample; valid on every clk.
- write_en  in  1  arms triggering when high.
- exttrg  in  1  trigger, synchronous to clk; rising edge starts an event.
- fifo_writedata  out  32  word to the FIFO sink.
- fifo_write  out  1  write request.
- fifo_waitrequest  in  1  sink stall.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky; set on any dropped data word; cleared on rst only.
- event_count  out  24  events completed; wraps from 0xFFFFFF to 0.
- trg_missed  out  16  rejected triggers; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; buffer empty.
  - trg_prev = 0, so exttrg already high when rst releases counts as an edge.
- Trigger edge detection:
  - trg_edge = exttrg & ~trg_prev, where trg_prev is exttrg registered.
  - The edge is evaluated in the same cycle exttrg is first sampled high.
- State machine, states IDLE, HDR, CAPT, TRL:
  - IDLE → HDR when trg_edge & write_en & buffer not full.
  - trg_edge & write_en & buffer full in IDLE: trigger rejected, trg_missed += 1.
  - trg_edge with write_en low: ignored, not counted.
  - trg_edge in HDR, CAPT or TRL: ignored, not counted.
  - HDR (1 cycle): push header {8'hA5, event_count[23:0]}; → CAPT.
  - CAPT:
    - Sample adc_data every cycle; sample counter 0..NSAMPLES-1.
    - Even-index sample is held in a register.
    - Odd-index sample completes the word {2'b10, held[13:0], 2'b00, cur[13:0]}, pushed that cycle.
    - After sample NSAMPLES-1 → TRL.
  - TRL:
    - Push trailer {8'h5A, 7'b0, ovf_evt, NSAMPLES[15:0]} when buffer not full; otherwise stay in TRL.
    - On push: event_count += 1; → IDLE.
- ovf_evt: per-event flag; cleared entering HDR; set on any dropped word in the event.
- Timing from the trg_edge cycle k:
  - Header pushed at k+1.
  - First sample taken at k+2.
  - Last sample at k+1+NSAMPLES.
  - Trailer pushed at k+2+NSAMPLES at the earliest.
  - Earliest next accepted edge at k+3+NSAMPLES.
- write_en deasserted mid-event: the event completes normally.
- Buffer:
  - Synchronous FIFO of BUF_DEPTH x 32.
  - A data push while full drops that word; sets ovf and ovf_evt. Capture timing is not altered.
  - The header cannot overflow: it is gated at trigger acceptance.
  - The trailer is never dropped: TRL waits instead.
  - A push and a pop in the same cycle are both allowed at any occupancy. With the buffer full, a same-cycle pop frees the slot and the push succeeds.
- Avalon write master:
  - fifo_write/fifo_writedata are registered.
  - When idle and the buffer is non-empty: load the head word and assert fifo_write on the next cycle.
  - Hold fifo_writedata stable and fifo_write high while fifo_waitrequest = 1.
  - A word is accepted on a cycle with fifo_write = 1 and fifo_waitrequest = 0.
  - After acceptance, load the next word back-to-back if available (1 word/cycle sustained); otherwise deassert fifo_write.
  - Latency from push into an empty buffer to fifo_write high: 2 cycles.
- Order on the port: header, NSAMPLES/2 data words (minus dropped words), trailer; never interleaved across events.
- rst mid-event: aborts immediately; buffer flushed; no partial trailer; counters cleared.

Test Plan:
- Basic event: NSAMPLES=4, adc_data = 0x0001, 0x0002, 0x0003, 0x0004, waitrequest=0, trigger → port sees 0xA5000000, 0x80010002, 0x80030004, 0x5A000004; event_count=1; busy low 1 cycle after the trailer push.
- Back-pressure, no loss: NSAMPLES=8, BUF_DEPTH=16, waitrequest=1 for 20 cycles then 0 → all 6 words delivered in order; each fifo_writedata held stable while stalled; ovf=0.
- Overflow: NSAMPLES=64, BUF_DEPTH=4, waitrequest held 1 until TRL is reached → ovf=1; trailer bit16=1; buffer held at 4 until release; trailer delivered after the release.
- Trigger rules:
  - exttrg pulsed during CAPT → ignored, trg_missed unchanged.
  - exttrg held high 10 cycles → one event only.
  - trigger with write_en=0 → no words, trg_missed unchanged.
  - trigger in IDLE with buffer full → trg_missed=1.
- Counter wrap: preload event_count to 0xFFFFFF via force, run one event → header carries 0xFFFFFF; event_count reads 0 afterwards.
- Reset mid-event: assert rst at sample 10 of 64 → fifo_write=0 and busy=0 immediately; the next trigger produces a clean header with event_count=0.
